// File: rtl/word_serializer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | word_serializer_pkg                                                    |
// | Lane/address constants and FSM states shared by serializer & unpacker. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package word_serializer_pkg;

  localparam int WIDE_W     = 128;
  localparam int NARROW_W   = 32;
  localparam int BEATS      = WIDE_W / NARROW_W;
  localparam int ADDR_W     = 4;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int BYTE_SHIFT = $clog2(NARROW_W / 8);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage : word_serializer_pkg
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | word_serializer                                                        |
// | 128-bit to 32-bit serializer, little-endian lanes with byte addresses. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module word_serializer
  import word_serializer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   in_data,
  input  logic [CNT_W-1:0]    in_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NARROW_W-1:0] out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_last,
  output logic                busy
);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDE_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_beat_fire;
  logic                w_last_fire;
  logic                w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs derive only from registers; in_ready alone looks at out_ready
  // so a new word can be taken on the last beat without a bubble.
  always_comb begin
    w_state_next = r_state;
    out_valid    = (r_state == SEND);
    busy         = (r_state == SEND);
    out_last     = (r_state == SEND) && (r_cnt == r_len);
    out_data     = r_hold[r_cnt*NARROW_W +: NARROW_W];
    out_addr     = ADDR_W'(r_cnt) << BYTE_SHIFT;
    w_beat_fire  = out_valid && out_ready;
    w_last_fire  = w_beat_fire && out_last;
    in_ready     = (r_state == IDLE) || w_last_fire;
    w_accept     = in_valid && in_ready;
    case (r_state)
      IDLE: if (w_accept) w_state_next = SEND;
      SEND: if (w_last_fire && !w_accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Counter returns to 0 after the last beat so an idle block shows address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_hold <= in_data;
      r_len  <= in_len;
      r_cnt  <= '0;
    end else if (w_beat_fire) begin
      if (out_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : word_serializer
`default_nettype wire

// File: doc/word_serializer.md
# word_serializer

Wide-to-narrow serializer: accepts one 128-bit word per valid/ready handshake and emits it as up to four 32-bit beats, each tagged with its byte address (0x0, 0x4, 0x8, 0xC). It is the transmit-side counterpart of the 32-to-128 unpacker and drives the same address/data lane convention, so its output reassembles correctly in the unpacker.

## Interface
- WIDE_W, 128, input word width.
- NARROW_W, 32, beat width; WIDE_W must be an integer multiple of NARROW_W.
- BEATS, WIDE_W/NARROW_W (4), derived and not overridable.
- ADDR_W, 4, width of the beat byte address.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  wide word offered.
- in_ready  out  1  serializer can take a word this cycle.
- in_data  in  WIDE_W  wide word; lane k is bits [32k+31:32k].
- in_len  in  2  number of beats to send minus 1 (0..3); sampled with in_data.
- out_valid  out  1  beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NARROW_W  beat data.
- out_addr  out  ADDR_W  byte address of the beat: beat index × 4.
- out_last  out  1  final beat of the current word.
- busy  out  1  word held, beats outstanding.

## Operation
- States: IDLE (no word held) and SEND (word held, beats outstanding).
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). Back-to-back words therefore have no bubble.
- Accept: in_valid && in_ready. The block loads in_data and in_len into hold registers, clears the beat counter to 0, and enters SEND.
- In SEND, out_valid = 1, out_data = hold lane[cnt], out_addr = cnt × 4, and out_last = (cnt == len).
- Beat handshake (out_valid && out_ready):
  - Not last: cnt increments.
  - Last with no simultaneous accept: return to IDLE and drop out_valid.
  - Last with a simultaneous accept: reload the hold registers, set cnt = 0, stay in SEND.
- Lane order is fixed little-endian: beat 0 is bits [31:0] at address 0x0, and beat 3 is bits [127:96] at address 0xC.
- Backpressure: while out_valid && !out_ready, out_data, out_addr and out_last stay stable.
- in_data and in_len are ignored unless an accept occurs. Changes to them during SEND have no effect.
- in_len = 0 sends a single beat at 0x0 with out_last = 1.
- No output depends combinationally on in_valid, in_data or in_len. out_valid, out_data, out_addr and out_last come from registers only. in_ready does depend combinationally on out_ready.

## Timing
- Reset (asynchronous assert, synchronous release) puts the block in IDLE with cnt = 0 and hold registers = 0. Reset output values:
  - out_valid = 0, out_data = 0, out_addr = 0, out_last = 0, busy = 0.
  - in_ready = 1.
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N.
- Throughput: with out_ready held at 1, one beat per cycle. A 4-beat word takes 4 cycles, and words stream continuously.
- Reset asserted mid-word discards the remaining beats immediately. No partial word is emitted after release.
- out_ready asserted while out_valid = 0 has no effect.

## Structure
- A shared package holds the constants WIDE_W, NARROW_W, BEATS and ADDR_W, and the state enum {IDLE, SEND}. The unpacker imports the same package so both ends agree on lane order and addresses.
- Single module; no sub-module is warranted. The lane select is an indexed part-select on the hold register.

## Test plan
- Reset, then one word 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA with in_len = 3 and out_ready held at 1:
  - beats (0x0, AAAAAAAA), (0x4, BBBBBBBB), (0x8, CCCCCCCC), (0xC, DDDDDDDD);
  - out_last only on the 4th beat;
  - in_ready returns to 1 in the last beat's cycle.
- Two words offered back-to-back with out_ready = 1 -> 8 consecutive beats with no gap. The second word's beat 0 is at address 0x0.
- out_ready toggled 1,0,0,1,… during a word -> each beat is held stable while stalled. No beat is lost or duplicated, and addresses run 0, 4, 8, C in order.
- in_len = 0 with data 0x…_12345678 -> a single beat (0x0, 12345678) with out_last = 1. in_len = 1 -> beats at 0x0 and 0x4 only.
- rst pulsed after beat 1 of a 4-beat word -> out_valid = 0 within the same cycle. After release, in_ready = 1 and no beats at 0x8 or 0xC appear.
- Loopback through the unpacker with 50 random words and in_len = 3 -> every reassembled 128-bit word equals the one sent.
